// File: rtl/uart_rx_if.sv
// ============================================================================
// uart_rx_if : serial line input and received-byte outputs of uart_rx
// Rev 1.0
// ============================================================================
`default_nettype none

interface uart_rx_if;
  logic       rx;
  logic [7:0] datorx;
  logic       valido;
  logic       error_trama;
  logic       ocupado;

  modport master (
    output rx,
    input  datorx,
    input  valido,
    input  error_trama,
    input  ocupado
  );

  modport slave (
    input  rx,
    output datorx,
    output valido,
    output error_trama,
    output ocupado
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8N1 serial receiver with mid-bit sampling and frame-error pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  wire logic clk,
  input  wire logic rst_n,
  uart_rx_if.slave  bus
);

  localparam int CICLOS_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT   = CICLOS_BIT / 2;
  localparam int CW         = (CICLOS_BIT > 1) ? $clog2(CICLOS_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CICLOS_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    INICIO = 2'd1,
    DATOS  = 2'd2,
    PARADA = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    indice, indice_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    dato, dato_n;
  logic          valido, valido_n;
  logic          error_trama, error_n;
  logic          rx_m, rx_s, rx_s_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= REPOSO;
      cnt         <= '0;
      indice      <= '0;
      shreg       <= '0;
      dato        <= 8'h00;
      valido      <= 1'b0;
      error_trama <= 1'b0;
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      rx_s_d      <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      indice      <= indice_n;
      shreg       <= shreg_n;
      dato        <= dato_n;
      valido      <= valido_n;
      error_trama <= error_n;
      rx_m        <= bus.rx;
      rx_s        <= rx_m;
      rx_s_d      <= rx_s;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    indice_n = indice;
    shreg_n  = shreg;
    dato_n   = dato;
    valido_n = 1'b0;
    error_n  = 1'b0;
    case (state)
      REPOSO: begin
        cnt_n    = '0;
        indice_n = '0;
        // Edge-triggered so a line stuck low cannot start repeated frames.
        if (rx_s_d && !rx_s) state_n = INICIO;
      end
      INICIO: begin
        if (cnt == HALF_LAST) begin
          cnt_n    = '0;
          indice_n = '0;
          state_n  = rx_s ? REPOSO : DATOS;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATOS: begin
        if (cnt == BIT_LAST) begin
          cnt_n          = '0;
          shreg_n[indice] = rx_s;
          indice_n       = indice + 3'd1;
          if (indice == 3'd7) state_n = PARADA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PARADA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = REPOSO;
          if (rx_s) begin
            dato_n   = shreg;
            valido_n = 1'b1;
          end else begin
            error_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = REPOSO;
    endcase
  end

  assign bus.datorx      = dato;
  assign bus.valido      = valido;
  assign bus.error_trama = error_trama;
  assign bus.ocupado     = (state != REPOSO);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : directed and random frames checked against a byte-queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;
  localparam int CB  = 50000000 / 115200;
  localparam int HB  = CB / 2;
  // start edge -> valido: 2 sync flops + edge, half bit, 9 full bits
  localparam int LAT = 9 * CB + HB + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  uart_rx_if bus_if ();

  uart_rx #(.CLK_FREQ(50000000), .BAUD(115200)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int nvalid = 0, nerr = 0, nocc = 0, exp_err = 0;
  int v0, occ0;
  logic prev_v = 1'b0, prev_e = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] last_good = 8'h00;
  logic [7:0] rb;
  logic       rst_stop;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_if.ocupado) nocc++;
    if (bus_if.valido || bus_if.error_trama)
      check("pulse_exclusive", 32'(bus_if.valido & bus_if.error_trama), 32'd0);
    if (bus_if.valido) begin
      nvalid++;
      got_q.push_back(bus_if.datorx);
      check("valido_width", 32'(prev_v), 32'd0);
      check("valido_latency", 32'((cyc - start_cyc) inside {[LAT-2:LAT+2]}), 32'd1);
    end
    if (bus_if.error_trama) begin
      nerr++;
      check("error_width", 32'(prev_e), 32'd0);
    end
    prev_v = bus_if.valido;
    prev_e = bus_if.error_trama;
  end

  task automatic idle(input int n);
    bus_if.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // rst_bit >= 0 pulses reset for one clock inside that frame bit (frame aborted)
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rst_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      bus_if.rx = f[i];
      for (int c = 0; c < CB; c++) begin
        @(negedge clk);
        if (i == rst_bit && c == 200) begin
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
        end
      end
    end
    if (rst_bit < 0) begin
      if (stop_bit) begin
        exp_q.push_back(b);
        last_good = b;
      end else begin
        exp_err++;
      end
    end
  endtask

  task automatic verify(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
    check({tag, "_errcnt"}, 32'(nerr), 32'(exp_err));
    check({tag, "_datorx"}, 32'(bus_if.datorx), 32'(last_good));
  endtask

  initial begin
    bus_if.rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_datorx", 32'(bus_if.datorx), 32'h00);
    check("rst_valido", 32'(bus_if.valido), 32'd0);
    check("rst_error", 32'(bus_if.error_trama), 32'd0);
    check("rst_ocupado", 32'(bus_if.ocupado), 32'd0);
    rst_n = 1'b1;
    idle(50);

    send_frame(8'h55, 1'b1, -1);
    idle(100);
    send_frame(8'hA3, 1'b1, -1);
    idle(100);
    verify("basic");

    v0   = nvalid;
    occ0 = nocc;
    bus_if.rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(600);
    check("glitch_busy_len", 32'((nocc - occ0) inside {[HB-2:HB+5]}), 32'd1);
    check("glitch_valid", 32'(nvalid), 32'(v0));
    check("glitch_idle", 32'(bus_if.ocupado), 32'd0);
    verify("glitch");

    send_frame(8'h3C, 1'b0, -1);
    idle(300);
    verify("stop_err");

    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    send_frame(8'h81, 1'b1, -1);
    idle(100);
    verify("b2b");

    v0 = nvalid;
    send_frame(8'hF0, 1'b1, 5);
    last_good = 8'h00;
    idle(100);
    check("abort_valid", 32'(nvalid), 32'(v0));
    check("abort_idle", 32'(bus_if.ocupado), 32'd0);
    verify("abort");
    send_frame(8'h12, 1'b1, -1);
    idle(100);
    verify("after_abort");

    rst_n = 1'b0;
    bus_if.rx = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_good = 8'h00;
    exp_err++;
    v0 = nvalid;
    repeat (20 * CB) @(negedge clk);
    check("stuck_low_busy", 32'(bus_if.ocupado), 32'd0);
    idle(1000);
    check("stuck_low_valid", 32'(nvalid), 32'(v0));
    verify("stuck_low");

    for (int k = 0; k < 3; k++) begin
      rb       = 8'($urandom_range(0, 255));
      rst_stop = ($urandom_range(0, 3) != 0);
      send_frame(rb, rst_stop, -1);
      idle(int'($urandom_range(20, 200)));
    end
    idle(100);
    verify("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate in baud.
REQ-003 Derived constant CICLOS_BIT = CLK_FREQ/BAUD (integer division; 434 at defaults) SHALL set the clocks per bit; HALF_BIT = CICLOS_BIT/2 (217 at defaults).
REQ-004 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 rx  input  1  asynchronous serial line, idle high.
REQ-007 datorx  output  8  last correctly received byte.
REQ-008 valido  output  1  one-clk pulse: datorx holds a new byte.
REQ-009 error_trama  output  1  one-clk pulse: stop bit sampled low.
REQ-010 ocupado  output  1  high while a frame is being received.

Function
REQ-011 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-012 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rx_s); the previous value is rx_s_d.
REQ-013 The state machine SHALL have states REPOSO, INICIO, DATOS, PARADA; an illegal encoding SHALL go to REPOSO next cycle.
REQ-014 REPOSO: a falling edge (rx_s_d=1, rx_s=0) SHALL enter INICIO with the bit counter cleared; a line held low SHALL NOT retrigger.
REQ-015 INICIO: when the counter reaches HALF_BIT-1, rx_s SHALL be sampled; 0 enters DATOS with the counter and bit index cleared; 1 is a glitch and returns to REPOSO with no output pulse.
REQ-016 DATOS: every CICLOS_BIT clocks, rx_s SHALL be sampled at mid-bit into shift register position indice (0..7), then indice increments; after the sample at indice=7, the FSM enters PARADA.
REQ-017 PARADA: after CICLOS_BIT clocks, rx_s SHALL be sampled; 1 loads datorx from the shift register and pulses valido; 0 pulses error_trama and leaves datorx unchanged; both cases then return to REPOSO.
REQ-018 valido and error_trama SHALL be registered, high for exactly one clk, and never high together.
REQ-019 Latency: valido SHALL rise within 2 clks after the mid-stop-bit sample; the total is roughly 9.5 bit times plus 3 clks after the start edge on rx.
REQ-020 datorx SHALL hold its value until the next valid frame.
REQ-021 ocupado SHALL be 1 in INICIO, DATOS and PARADA, and 0 in REPOSO.
REQ-022 The bit-timing counter SHALL be ceil(log2(CICLOS_BIT)) bits wide and wrap to 0 at CICLOS_BIT-1.
REQ-023 A falling edge arriving during PARADA, immediately after the stop sample, SHALL be caught on the first REPOSO cycle (back-to-back frames with zero idle time).

Reset
REQ-024 While rst_n=0 at a rising clk, the block SHALL set: state REPOSO; counters 0; shift register 0; datorx 8'h00; valido 0; error_trama 0; ocupado 0; synchronizer flops 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no valido or error_trama; reception resumes on the first falling edge after rst_n=1.

Verification
REQ-026 Bench SHALL drive 0x55 at 115200 baud (434 clks/bit), then 0xA3 -> valido pulses once per frame; datorx = 8'h55, then 8'hA3; error_trama stays 0.
REQ-027 Bench SHALL drive a 100-clk low glitch on idle rx -> no valido, no error_trama; ocupado high for about 219 clks, then 0.
REQ-028 Bench SHALL drive 0x3C with the stop bit forced 0 -> one error_trama pulse; datorx keeps its previous value; no valido.
REQ-029 Bench SHALL drive back-to-back 0x00, 0xFF, 0x81 with no idle between stop and start -> three valido pulses with the correct data, in order.
REQ-030 Bench SHALL assert rst_n=0 for 1 clk during data bit 4 of 0xF0, then send 0x12 -> no pulse for the aborted frame; valido with datorx = 8'h12.
REQ-031 Bench SHALL hold rx low for 20 bit times after reset -> exactly one error_trama, no further pulses until rx returns high and falls again.
